// File: rtl/div_sequencer_if.sv
// div_sequencer_if: request/result bundle between EX-stage decode and the divider
interface div_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      div_op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output start, div_op, op1, op2, flush, input busy, stall, done, result);
  modport slave (input start, div_op, op1, op2, flush, output busy, stall, done, result);
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_sequencer #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  div_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_rem, r_dvd, r_dvs, r_result;
  logic [1:0]      r_op;
  logic            r_neg_q, r_neg_r;
  logic            w_signed, w_sgn1, w_sgn2, w_div0, w_ovf, w_ge;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic [XLEN-1:0] w_q, w_r, w_special;
  assign w_signed  = ~bus.div_op[0];
  assign w_sgn1    = w_signed & bus.op1[XLEN-1];
  assign w_sgn2    = w_signed & bus.op2[XLEN-1];
  assign w_div0    = bus.op2 == '0;
  assign w_ovf     = w_signed & (bus.op1 == MIN_NEG) & (&bus.op2);
  assign w_special = w_div0 ? (bus.div_op[1] ? bus.op1 : '1) : (bus.div_op[1] ? '0 : MIN_NEG);
  // the quotient bits shift into r_dvd as the dividend bits shift out
  assign w_rem_sh  = {r_rem, r_dvd[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[XLEN];
  assign w_q       = r_neg_q ? -r_dvd : r_dvd;
  assign w_r       = r_neg_r ? -r_rem : r_rem;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (bus.flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_op    <= bus.div_op;
          r_neg_q <= w_sgn1 ^ w_sgn2;
          r_neg_r <= w_sgn1;
          r_dvd   <= w_sgn1 ? -bus.op1 : bus.op1;
          r_dvs   <= w_sgn2 ? -bus.op2 : bus.op2;
          r_rem   <= '0;
          r_count <= CW'(XLEN - 1);
          if (w_div0 | w_ovf) r_result <= w_special;
          r_state <= (w_div0 | w_ovf) ? DONE : CALC;
        end
        CALC: begin
          r_rem   <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
          r_dvd   <= {r_dvd[XLEN-2:0], w_ge};
          r_count <= (r_count == '0) ? r_count : r_count - 1'b1;
          r_state <= (r_count == '0) ? FIX : CALC;
        end
        FIX: begin
          r_result <= r_op[1] ? w_r : w_q;
          r_state  <= DONE;
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy   = (r_state == CALC) || (r_state == FIX);
  assign bus.done   = r_state == DONE;
  assign bus.stall  = bus.busy | (bus.start & (r_state == IDLE));
  assign bus.result = r_result;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vectors, scoreboard queue checked by a done-driven monitor
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] last_res = '0;
  typedef struct {logic [31:0] res; int lat; int t0;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  div_sequencer_if bus ();
  div_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
      end
    end
  end

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int t0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.div_op = op;
    bus.op1 = a;
    bus.op2 = b;
    #1 chk("stall_on_start", {31'b0, bus.stall}, 32'd1);
    @(posedge clk);
    #1 t0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input bit scramble);
    int t0;
    bit got = 1'b0;
    accept(op, a, b, t0);
    sb.push_back('{exp, lat, t0});
    last_res = exp;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (scramble) begin
        bus.op1 = $urandom;
        bus.op2 = $urandom;
        bus.div_op = 2'($urandom);
        bus.start = (k < 30) && (k % 3 == 0);
      end
      if (k == 1) chk("busy_first", {31'b0, bus.busy}, {31'b0, lat > 1});
      if (k == 33 && lat > 1) chk("busy_fix", {31'b0, bus.busy}, 32'd1);
      if (bus.done) begin
        got = 1'b1;
        chk("busy_in_done", {31'b0, bus.busy}, 32'd0);
        chk("stall_in_done", {31'b0, bus.stall}, 32'd0);
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_pulse", {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.div_op = 2'b00;
    bus.op1 = '0;
    bus.op2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    rst = 1'b0;
    run(2'b01, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    run(2'b11, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    run(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1'b0);
    run(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b0);
    run(2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0);
    run(2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34, 1'b0);
    run(2'b00, 32'h80000000, 32'd2, 32'hC0000000, 34, 1'b0);
    run(2'b00, 32'd0, 32'd5, 32'd0, 34, 1'b0);
    run(2'b01, 32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 34, 1'b0);
    run(2'b01, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run(2'b11, 32'h1234, 32'd0, 32'h1234, 1, 1'b0);
    run(2'b00, 32'd0, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);
    run(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34, 1'b0);
    run(2'b01, 32'd1000, 32'd10, 32'd100, 34, 1'b1);
    accept(2'b01, 32'd1000, 32'd7, t0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_result_held", bus.result, last_res);
    run(2'b01, 32'd9, 32'd3, 32'd3, 34, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.div_op = 2'b01;
    bus.op1 = 32'd50;
    bus.op2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", {31'b0, bus.busy}, 32'd0);
    chk("flush_start_done", {31'b0, bus.done}, 32'd0);
    accept(2'b01, 32'd500, 32'd3, t0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.done}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_stall", {31'b0, bus.stall}, 32'd0);
    repeat (40) @(negedge clk);
    run(2'b11, 32'd1000, 32'd7, 32'd6, 34, 1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
